// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: reads RAMProc back in VGA scan order and centres the processed image on the 640x480 screen.
// Define FBR_BORDER_EN to draw a one-pixel white frame around the image window.
module frame_buffer_reader #(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2,
  parameter int SCR_W  = 640,
  parameter int SCR_H  = 480
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIX_EN,
  input  logic              BUF_READY,
  input  logic [1:0]        IMAGE_STATE,
  input  logic [9:0]        NEXT_X,
  input  logic [9:0]        NEXT_Y,
  output logic [ADDR_W-1:0] R_ADDR,
  input  logic [7:0]        RD_DATA,
  output logic [7:0]        COLOR_OUT,
  output logic              IN_WINDOW,
  output logic              FRAME_START,
  output logic [1:0]        ACTIVE_STATE
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SCAN} state_t;
  state_t state, state_nx;
  logic [9:0] wid, hgt, x0, y0, col;
  logic [ADDR_W-1:0] line_base;
  logic [RD_LAT:0] vld_p, win_p;
  logic [7:0] fill;
  logic arm, last_pix, scan_pix, in_win, row_end;
  always_comb begin
    wid = ACTIVE_STATE == 2'd1 ? 10'd320 : ACTIVE_STATE == 2'd2 ? 10'd80 : ACTIVE_STATE == 2'd3 ? 10'd40 : 10'd160;
    hgt = ACTIVE_STATE == 2'd1 ? 10'd240 : ACTIVE_STATE == 2'd2 ? 10'd60 : ACTIVE_STATE == 2'd3 ? 10'd30 : 10'd120;
    x0 = ACTIVE_STATE == 2'd1 ? 10'd160 : ACTIVE_STATE == 2'd2 ? 10'd280 : ACTIVE_STATE == 2'd3 ? 10'd300 : 10'd240;
    y0 = ACTIVE_STATE == 2'd1 ? 10'd120 : ACTIVE_STATE == 2'd2 ? 10'd210 : ACTIVE_STATE == 2'd3 ? 10'd225 : 10'd180;
    in_win = NEXT_X >= x0 && NEXT_X < x0 + wid && NEXT_Y >= y0 && NEXT_Y < y0 + hgt;
    row_end = NEXT_X == x0 + wid - 10'd1;
    col = NEXT_X - x0;
    arm = BUF_READY && PIX_EN && state == WAIT_FRAME && NEXT_X == 10'd0 && NEXT_Y == 10'd0;
    last_pix = PIX_EN && NEXT_X == 10'(SCR_W - 1) && NEXT_Y == 10'(SCR_H - 1);
    scan_pix = BUF_READY && PIX_EN && state == SCAN;
    state_nx = !BUF_READY ? IDLE :
               state == IDLE ? WAIT_FRAME :
               arm ? SCAN :
               state == SCAN && last_pix ? WAIT_FRAME : state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      R_ADDR <= '0;
      line_base <= '0;
      COLOR_OUT <= 8'h00;
      IN_WINDOW <= 1'b0;
      FRAME_START <= 1'b0;
      ACTIVE_STATE <= 2'd0;
      vld_p <= '0;
      win_p <= '0;
    end else begin
      state <= state_nx;
      FRAME_START <= arm;
      if (arm) begin
        ACTIVE_STATE <= IMAGE_STATE;
        line_base <= '0;
      end
      if (scan_pix && in_win) begin
        R_ADDR <= line_base + ADDR_W'(col);
        if (row_end) line_base <= line_base + ADDR_W'(wid);
      end
      vld_p <= {vld_p[RD_LAT-1:0], PIX_EN};
      win_p <= {win_p[RD_LAT-1:0], scan_pix && in_win};
      // RD_DATA for the sampled pixel is valid RD_LAT cycles after R_ADDR registers
      if (!BUF_READY) begin
        vld_p <= '0;
        win_p <= '0;
        COLOR_OUT <= 8'h00;
        IN_WINDOW <= 1'b0;
      end else if (vld_p[RD_LAT]) begin
        COLOR_OUT <= win_p[RD_LAT] ? RD_DATA : fill;
        IN_WINDOW <= win_p[RD_LAT];
      end
    end
  end
`ifdef FBR_BORDER_EN
  logic [RD_LAT:0] bord_p;
  logic in_bord;
  always_comb in_bord = !in_win && NEXT_X >= x0 - 10'd1 && NEXT_X <= x0 + wid && NEXT_Y >= y0 - 10'd1 && NEXT_Y <= y0 + hgt;
  always_ff @(posedge CLK) bord_p <= RESET || !BUF_READY ? '0 : {bord_p[RD_LAT-1:0], scan_pix && in_bord};
  assign fill = bord_p[RD_LAT] ? 8'hFF : 8'h00;
`else
  assign fill = 8'h00;
`endif
endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: directed scan of frame_buffer_reader against a 2-cycle RAM returning addr[7:0].
module tb_frame_buffer_reader;
  logic CLK = 0, RESET = 1, PIX_EN = 0, BUF_READY = 0;
  logic [1:0] IMAGE_STATE = 0, ACTIVE_STATE;
  logic [9:0] NEXT_X = 0, NEXT_Y = 0;
  logic [16:0] R_ADDR, s_addr;
  logic [7:0] RD_DATA = 0, d1 = 0, COLOR_OUT, s_col, s_early;
  logic IN_WINDOW, FRAME_START, s_win, s_fs;
  int n_cmp = 0, n_bad = 0, fs_cnt = 0, gap = 99, f0;
`ifdef FBR_BORDER_EN
  localparam logic [7:0] BORD = 8'hFF;
`else
  localparam logic [7:0] BORD = 8'h00;
`endif
  frame_buffer_reader dut (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .BUF_READY(BUF_READY), .IMAGE_STATE(IMAGE_STATE),
    .NEXT_X(NEXT_X), .NEXT_Y(NEXT_Y), .R_ADDR(R_ADDR), .RD_DATA(RD_DATA), .COLOR_OUT(COLOR_OUT),
    .IN_WINDOW(IN_WINDOW), .FRAME_START(FRAME_START), .ACTIVE_STATE(ACTIVE_STATE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    d1 <= R_ADDR[7:0];
    RD_DATA <= d1;
    if (FRAME_START) fs_cnt <= fs_cnt + 1;
    if (PIX_EN) begin
      assert (gap >= 3) else $error("pixel strobe while a read is in flight");
      gap <= 0;
    end else gap <= gap < 99 ? gap + 1 : gap;
  end
  task automatic check(input string tag, input logic [31:0] got, exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pix(input int x, y);
    NEXT_X = 10'(x);
    NEXT_Y = 10'(y);
    PIX_EN = 1;
    @(negedge CLK);
    PIX_EN = 0;
    s_addr = R_ADDR;
    s_fs = FRAME_START;
    @(negedge CLK);
    @(negedge CLK);
    s_early = COLOR_OUT;
    @(negedge CLK);
    s_col = COLOR_OUT;
    s_win = IN_WINDOW;
  endtask
  task automatic frame(input int w, h, x0, y0, input logic [1:0] st_mid);
    int c0, e;
    c0 = fs_cnt;
    pix(0, 0);
    check("frame_start", s_fs, 1);
    IMAGE_STATE = st_mid;
    pix(x0 - 1, y0);
    check("left_col", s_col, BORD);
    check("left_win", s_win, 0);
    for (int r = 0; r < h; r++) begin
      e = r * w;
      pix(x0, y0 + r);
      check("row_first_addr", s_addr, e);
      check("row_first_col", s_col, e & 255);
      check("row_first_win", s_win, 1);
      pix(x0 + w - 1, y0 + r);
      check("row_last_addr", s_addr, e + w - 1);
      check("row_last_early", s_early, e & 255);
      check("row_last_col", s_col, (e + w - 1) & 255);
    end
    pix(639, 479);
    check("frame_start_count", fs_cnt - c0, 1);
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_addr", R_ADDR, 0);
    check("rst_col", COLOR_OUT, 0);
    check("rst_win", IN_WINDOW, 0);
    check("rst_fs", FRAME_START, 0);
    check("rst_state", ACTIVE_STATE, 0);
    RESET = 0;
    BUF_READY = 1;
    repeat (2) @(negedge CLK);
    IMAGE_STATE = 0;
    frame(160, 120, 240, 180, 0);
    check("active_00", ACTIVE_STATE, 0);
    IMAGE_STATE = 1;
    frame(320, 240, 160, 120, 1);
    check("active_01", ACTIVE_STATE, 1);
    IMAGE_STATE = 0;
    frame(160, 120, 240, 180, 3);
    check("active_held", ACTIVE_STATE, 0);
    frame(40, 30, 300, 225, 3);
    check("active_11", ACTIVE_STATE, 3);
    IMAGE_STATE = 0;
    pix(0, 0);
    for (int r = 0; r < 10; r++) pix(399, 180 + r);
    pix(250, 190);
    check("pre_drop_addr", s_addr, 1610);
    check("pre_drop_col", s_col, 1610 & 255);
    NEXT_X = 251;
    PIX_EN = 1;
    @(negedge CLK);
    PIX_EN = 0;
    check("inflight_addr", R_ADDR, 1611);
    BUF_READY = 0;
    @(negedge CLK);
    check("drop_col", COLOR_OUT, 0);
    check("drop_win", IN_WINDOW, 0);
    repeat (2) @(negedge CLK);
    pix(252, 190);
    check("idle_addr", s_addr, 1611);
    check("idle_col", s_col, 0);
    BUF_READY = 1;
    repeat (2) @(negedge CLK);
    pix(253, 190);
    check("rearm_addr", s_addr, 1611);
    check("rearm_win", s_win, 0);
    pix(240, 191);
    check("rearm_addr2", s_addr, 1611);
    frame(160, 120, 240, 180, 0);
    IMAGE_STATE = 1;
    pix(0, 0);
    pix(160, 120);
    pix(161, 120);
    check("pre_rst_addr", s_addr, 1);
    check("pre_rst_state", ACTIVE_STATE, 1);
    f0 = fs_cnt;
    RESET = 1;
    @(negedge CLK);
    check("mid_rst_addr", R_ADDR, 0);
    check("mid_rst_col", COLOR_OUT, 0);
    check("mid_rst_state", ACTIVE_STATE, 0);
    repeat (2) @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    pix(162, 120);
    check("post_rst_addr", s_addr, 0);
    check("post_rst_win", s_win, 0);
    check("post_rst_fs", fs_cnt - f0, 0);
    IMAGE_STATE = 0;
    pix(0, 0);
    check("bord_arm", s_fs, 1);
    pix(239, 180);
    check("bord_left", s_col, BORD);
    check("bord_left_win", s_win, 0);
    pix(400, 250);
    check("bord_right", s_col, BORD);
    pix(300, 179);
    check("bord_top", s_col, BORD);
    pix(238, 180);
    check("outside_col", s_col, 0);
    pix(639, 479);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
